// File: rtl/reset_sequencer.sv
// Staged reset release: waits for a stable PLL lock, then releases each reset
// domain in turn, bit 0 first, one STAGGER_CYCLES apart.
module reset_sequencer #(
    parameter int NUM_RST         = 4,
    parameter int HOLD_CYCLES     = 10000,
    parameter int STAGGER_CYCLES  = 16,
    parameter int CNT_WIDTH       = 21,
    parameter int LOCK_LOSS_REARM = 1
) (
    input  logic               clk,
    input  logic               RSTb,
    input  logic               locked,
    input  logic               sw_rst_req,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               all_released,
    output logic [1:0]         state
);

    localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        HOLD      = 2'b01,
        RELEASE   = 2'b10,
        RUN       = 2'b11
    } st_t;

    st_t                state_q, state_nxt;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [NUM_RST-1:0] rst_nxt;
    logic               rel_nxt;
    logic               sync0, locked_s;
    logic               hold_done, stag_done, lock_drop;

    assign hold_done = (cnt_q == CNT_WIDTH'(HOLD_CYCLES - 1));
    assign stag_done = (cnt_q == CNT_WIDTH'(STAGGER_CYCLES - 1));
    // Lock loss only matters after release when re-arming is enabled.
    assign lock_drop = !locked_s && (LOCK_LOSS_REARM != 0);

    always_ff @(posedge clk) begin
        if (!RSTb) begin
            sync0        <= 1'b0;
            locked_s     <= 1'b0;
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            idx_q        <= '0;
            rst_n_out    <= '0;
            all_released <= 1'b0;
        end else begin
            sync0        <= locked;
            locked_s     <= sync0;
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            idx_q        <= idx_nxt;
            rst_n_out    <= rst_nxt;
            all_released <= rel_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (locked_s) state_nxt = HOLD;
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (hold_done) begin
                    state_nxt = (NUM_RST == 1) ? RUN : RELEASE;
                    cnt_nxt   = '0;
                    idx_nxt   = (NUM_RST == 1) ? '0 : IDX_W'(1);
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (lock_drop) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else if (sw_rst_req) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end else if (state_q == RELEASE) begin
                    if (stag_done) begin
                        cnt_nxt = '0;
                        if (idx_q == IDX_W'(NUM_RST - 1)) begin
                            state_nxt = RUN;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Next output values; idx_q is 0 in HOLD so the first release is bit 0.
    always_comb begin
        rst_nxt = rst_n_out;
        if (state_nxt == WAIT_LOCK || state_nxt == HOLD)
            rst_nxt = '0;
        else if ((state_q == HOLD) || (state_q == RELEASE && stag_done))
            rst_nxt = rst_n_out | (NUM_RST'(1) << idx_q);
        rel_nxt = (state_nxt == RUN);
    end

    assign state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: three configurations share one stimulus
// stream and are checked every cycle against a release-schedule model.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic RSTb = 1'b0, locked = 1'b0, sw_rst_req = 1'b0;
    logic [2:0] r0, r1;
    logic       r2;
    logic       ar0, ar1, ar2;
    logic [1:0] st0, st1, st2;

    reset_sequencer #(.NUM_RST(3), .HOLD_CYCLES(8), .STAGGER_CYCLES(4), .CNT_WIDTH(4),
                      .LOCK_LOSS_REARM(1)) u0 (
        .clk(clk), .RSTb(RSTb), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_n_out(r0), .all_released(ar0), .state(st0));
    reset_sequencer #(.NUM_RST(3), .HOLD_CYCLES(8), .STAGGER_CYCLES(4), .CNT_WIDTH(4),
                      .LOCK_LOSS_REARM(0)) u1 (
        .clk(clk), .RSTb(RSTb), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_n_out(r1), .all_released(ar1), .state(st1));
    reset_sequencer #(.NUM_RST(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .CNT_WIDTH(1),
                      .LOCK_LOSS_REARM(1)) u2 (
        .clk(clk), .RSTb(RSTb), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_n_out(r2), .all_released(ar2), .state(st2));

    logic [15:0] a_rst [3];
    logic [15:0] a_rel [3];
    logic [15:0] a_st  [3];
    assign a_rst[0] = 16'(r0);  assign a_rel[0] = 16'(ar0);  assign a_st[0] = 16'(st0);
    assign a_rst[1] = 16'(r1);  assign a_rel[1] = 16'(ar1);  assign a_st[1] = 16'(st1);
    assign a_rst[2] = 16'(r2);  assign a_rel[2] = 16'(ar2);  assign a_st[2] = 16'(st2);

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input int d, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    // Model: a domain is either waiting for lock, or k cycles past HOLD entry;
    // bit i is released once k reaches HOLD + i*STAGGER.
    int mH [3] = '{8, 8, 1};
    int mS [3] = '{4, 4, 1};
    int mN [3] = '{3, 3, 1};
    int mR [3] = '{1, 0, 1};
    bit m_s0 [3], m_s1 [3], m_act [3];
    int m_k [3];

    initial begin
        bit rb, lk, sw, ls, valid;
        int c;
        logic [15:0] e_rst, e_rel, e_st;
        valid = 0;
        for (int d = 0; d < 3; d++) begin
            m_s0[d] = 0; m_s1[d] = 0; m_act[d] = 0; m_k[d] = 0;
        end
        forever begin
            @(posedge clk);
            rb = RSTb; lk = locked; sw = sw_rst_req;
            #1;
            if (!rb) valid = 1;
            for (int d = 0; d < 3; d++) begin
                if (!rb) begin
                    m_s0[d] = 0; m_s1[d] = 0; m_act[d] = 0; m_k[d] = 0;
                end else begin
                    ls = m_s1[d];
                    if (!m_act[d]) begin
                        if (ls) begin m_act[d] = 1; m_k[d] = 0; end
                    end else if (m_k[d] < mH[d]) begin
                        if (!ls) m_act[d] = 0;
                        else     m_k[d]++;
                    end else begin
                        if (!ls && mR[d] != 0)  m_act[d] = 0;
                        else if (sw)            m_k[d] = 0;
                        else if (m_k[d] < mH[d] + mN[d] * mS[d]) m_k[d]++;
                    end
                    m_s1[d] = m_s0[d];
                    m_s0[d] = lk;
                end
                if (valid) begin
                    if (!m_act[d]) begin
                        e_rst = 0; e_st = 0; e_rel = 0;
                    end else if (m_k[d] < mH[d]) begin
                        e_rst = 0; e_st = 1; e_rel = 0;
                    end else begin
                        c = (m_k[d] - mH[d]) / mS[d] + 1;
                        if (c > mN[d]) c = mN[d];
                        e_rst = 16'((1 << c) - 1);
                        e_st  = (c < mN[d]) ? 16'd2 : 16'd3;
                        e_rel = (c == mN[d]) ? 16'd1 : 16'd0;
                    end
                    check("model_rst_n_out", d, a_rst[d], e_rst);
                    check("model_all_released", d, a_rel[d], e_rel);
                    check("model_state", d, a_st[d], e_st);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rst_n_out", 0, a_rst[0], 16'h0);
        check("reset_state", 0, a_st[0], 16'h0);
        RSTb = 1'b1;
        locked = 1'b1;
        // The next rising edge is edge 0 of the lock-to-release timeline.
        for (int e = 0; e <= 18; e++) begin
            @(posedge clk);
            #2;
            case (e)
                1:  check("lit_e1_state", 0, a_st[0], 16'h0);
                2:  begin
                        check("lit_e2_state", 0, a_st[0], 16'h1);
                        check("lit_e2_n1_rst", 2, a_rst[2], 16'h0);
                    end
                3:  begin
                        check("lit_e3_n1_rst", 2, a_rst[2], 16'h1);
                        check("lit_e3_n1_rel", 2, a_rel[2], 16'h1);
                        check("lit_e3_n1_state", 2, a_st[2], 16'h3);
                    end
                9:  check("lit_e9_rst", 0, a_rst[0], 16'h0);
                10: begin
                        check("lit_e10_rst", 0, a_rst[0], 16'h1);
                        check("lit_e10_state", 0, a_st[0], 16'h2);
                    end
                13: check("lit_e13_rst", 0, a_rst[0], 16'h1);
                14: check("lit_e14_rst", 0, a_rst[0], 16'h3);
                17: check("lit_e17_rel", 0, a_rel[0], 16'h0);
                18: begin
                        check("lit_e18_rst", 0, a_rst[0], 16'h7);
                        check("lit_e18_rel", 0, a_rel[0], 16'h1);
                        check("lit_e18_state", 0, a_st[0], 16'h3);
                        check("lit_e18_rst_norearm", 1, a_rst[1], 16'h7);
                    end
                default: ;
            endcase
        end
        @(negedge clk);
        locked = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("lit_lockloss_rst", 0, a_rst[0], 16'h0);
        check("lit_lockloss_state", 0, a_st[0], 16'h0);
        check("lit_lockloss_norearm_rst", 1, a_rst[1], 16'h7);
        check("lit_lockloss_norearm_state", 1, a_st[1], 16'h3);

        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            RSTb = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) locked = ~locked;
            sw_rst_req = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_RST, default 4: number of staged reset domains, legal range 1..16.
REQ-002 SHALL have parameter HOLD_CYCLES, default 10000: cycles lock must be continuously stable before the first release, min 1.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 16: cycles between successive domain releases, min 1.
REQ-004 SHALL have parameter CNT_WIDTH, default 21: counter width, able to hold max(HOLD_CYCLES, STAGGER_CYCLES)-1.
REQ-005 SHALL have parameter LOCK_LOSS_REARM, default 1: 1 = lock loss after release re-asserts all resets; 0 = ignored once released.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port RSTb  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port locked  input  1  PLL lock, asynchronous to clk.
REQ-009 SHALL have port sw_rst_req  input  1  synchronous software reset request, sampled each cycle.
REQ-010 SHALL have port rst_n_out  output  NUM_RST  per-domain active-low reset; bit i = domain i.
REQ-011 SHALL have port all_released  output  1  high when every rst_n_out bit is 1.
REQ-012 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-013 SHALL pass locked through a 2-flop synchronizer (locked_s); FSM uses only locked_s.
REQ-014 SHALL implement states WAIT_LOCK=00, HOLD=01, RELEASE=10, RUN=11, all outputs registered.
REQ-015 WAIT_LOCK: rst_n_out all 0, counter 0; locked_s=1 -> HOLD with counter 0.
REQ-016 HOLD: locked_s=0 -> WAIT_LOCK; else counter==HOLD_CYCLES-1 -> RELEASE, rst_n_out[0] set to 1 on that edge, counter 0, index 1; else counter+1.
REQ-017 RELEASE: counter==STAGGER_CYCLES-1 -> rst_n_out[index] set to 1, counter 0, index+1; else counter+1; releasing bit NUM_RST-1 moves to RUN on the same edge.
REQ-018 NUM_RST=1: HOLD exits directly to RUN, rst_n_out[0] and all_released set on the same edge.
REQ-019 Released bits SHALL stay 1 until an event in REQ-020..022; release order strictly bit 0 upward, never two bits on one edge (NUM_RST>1).
REQ-020 Lock loss (locked_s=0) in RELEASE or RUN with LOCK_LOSS_REARM=1 -> all rst_n_out 0, all_released 0, WAIT_LOCK on next edge; with LOCK_LOSS_REARM=0 no effect in those states.
REQ-021 sw_rst_req=1 in RELEASE or RUN -> all rst_n_out 0, all_released 0, counter 0, HOLD on next edge; ignored in WAIT_LOCK and HOLD.
REQ-022 Priority: RSTb > lock loss (REQ-020) > sw_rst_req; simultaneous lock loss and sw_rst_req -> WAIT_LOCK.
REQ-023 Latency: locked rising, stable before edge 0 -> locked_s high after edge 1, HOLD entered edge 2, rst_n_out[i] high after edge HOLD_CYCLES+2+i*STAGGER_CYCLES.
REQ-024 Counter SHALL never wrap; it is cleared on every state change.
REQ-025 all_released SHALL equal 1 exactly in RUN.

Reset
REQ-026 RSTb low at a rising edge SHALL force: state WAIT_LOCK, rst_n_out all 0, all_released 0, counter 0, index 0, synchronizer flops 0.
REQ-027 RSTb low mid-HOLD/RELEASE/RUN SHALL take effect on that edge regardless of other inputs; after RSTb high, sequencing restarts from REQ-023.

Verification (NUM_RST=3, HOLD_CYCLES=8, STAGGER_CYCLES=4 unless stated)
REQ-028 locked=1 before edge 0, RSTb high -> rst_n_out 001 after edge 10, 011 after 14, 111 and all_released=1 after 18; state=11.
REQ-029 locked drops for 1 cycle during HOLD (counter=5) -> WAIT_LOCK, on regain full 8-cycle hold restarts; no early release.
REQ-030 In RUN, pulse sw_rst_req 1 cycle -> rst_n_out 000 next edge, state HOLD, re-release at +8/+12/+16 cycles.
REQ-031 In RUN, locked=0: REARM=1 -> rst_n_out 000 within 3 edges, state 00; REARM=0 -> rst_n_out stays 111.
REQ-032 Lock loss and sw_rst_req together in RELEASE -> state WAIT_LOCK; RSTb low same cycle overrides both.
REQ-033 NUM_RST=1, HOLD_CYCLES=1 -> rst_n_out=1 and all_released=1 after edge 3.
